// File: rtl/snake_grid_vga.sv
`default_nettype none
// ============================================================================
// Module   : snake_grid_vga
// Purpose  : Display end of the snake game. Renders the ROWSxCOLS occupancy
//            grid and game flags as VGA video (640x480@60Hz by default).
//            Generates sync/blanking timing, snapshots the grid once per
//            frame so a frame never tears, maps each pixel to a grid cell
//            with counters (no dividers) and drives registered RGB.
// Ports    : clk          pixel clock, one pixel per cycle
//            rst          asynchronous active-low reset
//            grid         [ROWS-1:0][COLS-1:0] occupancy, grid[row][col]
//            state        game state, 2'b01 = playing
//            won, lost    game result flags
//            hsync, vsync active-low syncs
//            video_on     active pixel (DAC blank_n)
//            red/green/blue 8-bit colour channels
//            frame_start  1-cycle pulse aligned with pixel (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module snake_grid_vga #(
  parameter int ROWS     = 10,
  parameter int COLS     = 10,
  parameter int CELL_PX  = 40,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS-1:0][COLS-1:0] grid,
  input  logic [1:0]                state,
  input  logic                      won,
  input  logic                      lost,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      video_on,
  output logic [7:0]                red,
  output logic [7:0]                green,
  output logic [7:0]                blue,
  output logic                      frame_start
);

  localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(C_H_TOTAL);
  localparam int VW  = $clog2(C_V_TOTAL);
  localparam int SW  = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int CW  = $clog2(COLS + 1);
  localparam int RW  = $clog2(ROWS + 1);
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [HW-1:0] c_h_last     = HW'(C_H_TOTAL - 1);
  localparam logic [HW-1:0] c_h_act      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] c_hs_start   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] c_hs_end     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] c_v_last     = VW'(C_V_TOTAL - 1);
  localparam logic [VW-1:0] c_v_act      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] c_v_act_last = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] c_vs_start   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] c_vs_end     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [SW-1:0] c_sub_last   = SW'(CELL_PX - 1);
  localparam logic [CW-1:0] c_cols       = CW'(COLS);
  localparam logic [RW-1:0] c_rows       = RW'(ROWS);

  localparam logic [23:0] c_rgb_black  = 24'h000000;
  localparam logic [23:0] c_rgb_border = 24'h404040;
  localparam logic [23:0] c_rgb_green  = 24'h00FF00;
  localparam logic [23:0] c_rgb_red    = 24'hFF0000;
  localparam logic [23:0] c_rgb_white  = 24'hFFFFFF;
  localparam logic [23:0] c_rgb_dim    = 24'h000040;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [CW-1:0] r_col_cnt;
  logic [SW-1:0] r_col_sub;
  logic [RW-1:0] r_row_cnt;
  logic [SW-1:0] r_row_sub;

  logic [ROWS-1:0][COLS-1:0] r_grid;
  logic [1:0]                r_state;
  logic                      r_won;
  logic                      r_lost;

  logic           w_h_wrap;
  logic           w_v_wrap;
  logic           w_active;
  logic           w_in_grid;
  logic [CIW-1:0] w_col_idx;
  logic [RIW-1:0] w_row_idx;
  logic           w_occ;
  logic [23:0]    w_rgb;

  assign w_h_wrap = (r_h_cnt == c_h_last);
  assign w_v_wrap = (r_v_cnt == c_v_last);

  // Raster position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Column cell tracking: col_sub counts pixels inside a cell, col_cnt the
  // cell index. col_cnt parks at COLS once past the grid's right edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_cnt <= '0;
      r_col_sub <= '0;
    end else if (w_h_wrap) begin
      r_col_cnt <= '0;
      r_col_sub <= '0;
    end else if (r_h_cnt < c_h_act) begin
      if (r_col_sub == c_sub_last) begin
        r_col_sub <= '0;
        if (r_col_cnt != c_cols) r_col_cnt <= r_col_cnt + 1'b1;
      end else begin
        r_col_sub <= r_col_sub + 1'b1;
      end
    end
  end

  // Row cell tracking, stepped once per line and parked at ROWS below the grid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_cnt <= '0;
      r_row_sub <= '0;
    end else if (w_h_wrap) begin
      if (w_v_wrap) begin
        r_row_cnt <= '0;
        r_row_sub <= '0;
      end else if (r_v_cnt < c_v_act) begin
        if (r_row_sub == c_sub_last) begin
          r_row_sub <= '0;
          if (r_row_cnt != c_rows) r_row_cnt <= r_row_cnt + 1'b1;
        end else begin
          r_row_sub <= r_row_sub + 1'b1;
        end
      end
    end
  end

  // Frame snapshot taken at the last pixel slot of the last active line, so
  // the next frame renders a single consistent view of the game.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grid  <= '0;
      r_state <= '0;
      r_won   <= 1'b0;
      r_lost  <= 1'b0;
    end else if (w_h_wrap && (r_v_cnt == c_v_act_last)) begin
      r_grid  <= grid;
      r_state <= state;
      r_won   <= won;
      r_lost  <= lost;
    end
  end

  assign w_active  = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
  assign w_in_grid = (r_col_cnt < c_cols) && (r_row_cnt < c_rows);

  // Indices fall back to 0 outside the grid so the lookup stays in range;
  // the result is then masked by w_in_grid.
  assign w_col_idx = (r_col_cnt < c_cols) ? CIW'(r_col_cnt) : '0;
  assign w_row_idx = (r_row_cnt < c_rows) ? RIW'(r_row_cnt) : '0;
  assign w_occ     = w_in_grid && r_grid[w_row_idx][w_col_idx];

  always_comb begin
    w_rgb = c_rgb_black;
    if (!w_active) begin
      w_rgb = c_rgb_black;
    end else if (!w_in_grid) begin
      w_rgb = c_rgb_border;
    end else if (w_occ) begin
      if (r_won)       w_rgb = c_rgb_green;
      else if (r_lost) w_rgb = c_rgb_red;
      else             w_rgb = c_rgb_white;
    end else if (r_state != 2'b01) begin
      w_rgb = c_rgb_dim;
    end
  end

  // Output register stage: everything lags its counter value by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync              <= 1'b1;
      vsync              <= 1'b1;
      video_on           <= 1'b0;
      frame_start        <= 1'b0;
      {red, green, blue} <= '0;
    end else begin
      hsync              <= !((r_h_cnt >= c_hs_start) && (r_h_cnt <= c_hs_end));
      vsync              <= !((r_v_cnt >= c_vs_start) && (r_v_cnt <= c_vs_end));
      video_on           <= w_active;
      frame_start        <= (r_h_cnt == '0) && (r_v_cnt == '0);
      {red, green, blue} <= w_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_grid_vga.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_grid_vga
// Purpose  : Self-checking bench for snake_grid_vga. A reduced-timing instance
//            is checked every cycle against a raster model computed from
//            pixel position arithmetic; a default 640x480 instance runs in
//            parallel with literal spot values on its first lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_grid_vga;

  localparam int R   = 4;
  localparam int C   = 5;
  localparam int CP  = 3;
  localparam int HA  = 20;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 3;
  localparam int VA  = 16;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int NG  = R * C;
  localparam logic [27:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [R-1:0][C-1:0] grid = '0;
  logic [1:0] state = 2'b00;
  logic won = 1'b0;
  logic lost = 1'b0;

  logic hsync, vsync, video_on, frame_start;
  logic [7:0] red, green, blue;

  logic [9:0][9:0] d_grid = '0;
  logic [1:0] d_state = 2'b00;
  logic d_won = 1'b0;
  logic d_lost = 1'b0;
  logic d_hsync, d_vsync, d_video_on, d_frame_start;
  logic [7:0] d_red, d_green, d_blue;

  logic [27:0] s_vec;
  logic [27:0] s_dvec;
  assign s_vec  = {hsync, vsync, video_on, frame_start, red, green, blue};
  assign s_dvec = {d_hsync, d_vsync, d_video_on, d_frame_start, d_red, d_green, d_blue};

  snake_grid_vga #(
    .ROWS(R), .COLS(C), .CELL_PX(CP),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .grid(grid), .state(state), .won(won), .lost(lost),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  snake_grid_vga dut_full (
    .clk(clk), .rst(rst), .grid(d_grid), .state(d_state), .won(d_won), .lost(d_lost),
    .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
    .red(d_red), .green(d_green), .blue(d_blue), .frame_start(d_frame_start)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [R-1:0][C-1:0] m_grid = '0;
  logic [1:0] m_state = 2'b00;
  logic m_won = 1'b0;
  logic m_lost = 1'b0;
  int   m_pos = 0;
  int   out_x = 0, out_y = 0;
  logic out_valid = 1'b0;
  logic [27:0] e_vec = RESET_VEC;
  int   d_pos = 0, d_x = 0, d_y = 0;
  logic d_valid = 1'b0;

  function automatic logic [23:0] model_rgb(input int x, input int y);
    if (x >= HA || y >= VA) return 24'h000000;
    if (x >= C * CP || y >= R * CP) return 24'h404040;
    if (m_grid[y / CP][x / CP]) begin
      if (m_won) return 24'h00FF00;
      if (m_lost) return 24'hFF0000;
      return 24'hFFFFFF;
    end
    if (m_state != 2'b01) return 24'h000040;
    return 24'h000000;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_pos = 0; m_grid = '0; m_state = 2'b00; m_won = 1'b0; m_lost = 1'b0;
        e_vec = RESET_VEC; out_valid = 1'b0;
        d_pos = 0; d_valid = 1'b0;
      end else begin
        out_x = m_pos % HT;
        out_y = m_pos / HT;
        out_valid = 1'b1;
        e_vec = {!(out_x >= HA + HFP && out_x < HA + HFP + HS),
                 !(out_y >= VA + VFP && out_y < VA + VFP + VS),
                 (out_x < HA && out_y < VA),
                 (out_x == 0 && out_y == 0),
                 model_rgb(out_x, out_y)};
        if (out_x == HT - 1 && out_y == VA - 1) begin
          m_grid = grid; m_state = state; m_won = won; m_lost = lost;
        end
        m_pos = (m_pos + 1) % FRAME;
        d_x = d_pos % 800;
        d_y = d_pos / 800;
        d_valid = 1'b1;
        d_pos = (d_pos + 1) % 420000;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("pixel", {4'h0, s_vec}, {4'h0, e_vec});
      if (!rst) check("full_reset", {4'h0, s_dvec}, {4'h0, RESET_VEC});
      if (d_valid && d_y == 0) begin
        case (d_x)
          0:   check("full_x0",   {4'h0, s_dvec}, {4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000040});
          399: check("full_x399", {4'h0, s_dvec}, {4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000040});
          400: check("full_x400", {4'h0, s_dvec}, {4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h404040});
          639: check("full_x639", {4'h0, s_dvec}, {4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h404040});
          640: check("full_x640", {4'h0, s_dvec}, {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
          655: check("full_x655", {4'h0, s_dvec}, {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
          656: check("full_x656", {4'h0, s_dvec}, {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
          751: check("full_x751", {4'h0, s_dvec}, {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
          752: check("full_x752", {4'h0, s_dvec}, {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
          default: ;
        endcase
      end
      if (d_valid && d_y == 1 && d_x == 0)
        check("full_y1", {4'h0, s_dvec}, {4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000040});
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_pixel(input int x, input int y);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (out_valid && out_x == x && out_y == y) return;
    end
    check("wait_pixel_timeout", 32'd0, 32'd1);
  endtask

  task automatic next_frame;
    wait_pixel(0, VA + 1);
  endtask

  task automatic pin(input string name, input int x, input int y, input logic [23:0] exp);
    wait_pixel(x, y);
    check(name, {8'h0, red, green, blue}, {8'h0, exp});
  endtask

  logic [31:0] tmp;

  initial begin
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_hold", {4'h0, s_vec}, {4'h0, RESET_VEC});
    #1 rst = 1'b1;
    grid = '0; grid[0][0] = 1'b1; state = 2'b01;
    @(negedge clk);
    check("first_fs", {31'h0, frame_start}, 32'd1);
    check("first_rgb", {8'h0, red, green, blue}, 32'h000040);

    next_frame();
    pin("cell00",      0, 0, 24'hFFFFFF);
    pin("cell01",      3, 0, 24'h000000);
    pin("right_edge", 15, 0, 24'h404040);
    pin("cell00_end",  2, 2, 24'hFFFFFF);
    wait_pixel(0, 5);
    #1 grid[R-1][C-1] = 1'b1;
    pin("late_write", 12, 9, 24'h000000);
    pin("bottom",      0, 12, 24'h404040);

    next_frame();
    pin("cell_last",   12, 9, 24'hFFFFFF);
    pin("cell_last_e", 14, 11, 24'hFFFFFF);
    #1 lost = 1'b1;
    next_frame();
    pin("lost_occ",   0, 0, 24'hFF0000);
    pin("lost_empty", 3, 0, 24'h000000);
    #1 won = 1'b1;
    next_frame();
    pin("won_lost", 0, 0, 24'h00FF00);
    #1 won = 1'b0; lost = 1'b0; state = 2'b00;
    next_frame();
    pin("idle_occ",   0, 0, 24'hFFFFFF);
    pin("idle_empty", 3, 0, 24'h000040);

    // Runs past the first two lines of the full-size instance before reset.
    repeat (900) @(negedge clk);
    wait_pixel(10, 8);
    #1 rst = 1'b0;
    #1;
    check("midline_rst",      {4'h0, s_vec},  {4'h0, RESET_VEC});
    check("midline_rst_full", {4'h0, s_dvec}, {4'h0, RESET_VEC});
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rel_fs",      {31'h0, frame_start}, 32'd1);
    check("rel_fs_full", {31'h0, d_frame_start}, 32'd1);
    check("rel_rgb",     {8'h0, red, green, blue}, 32'h000040);

    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(1, FRAME)) @(negedge clk);
      #1;
      tmp = $urandom & $urandom;
      grid  = tmp[NG-1:0];
      state = 2'($urandom_range(0, 3));
      won   = ($urandom_range(0, 3) == 0);
      lost  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1 rst = 1'b1;
      end
    end
    repeat (2 * FRAME) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
